// File: rtl/aes_hpc_word_bridge_pkg.sv
// Shared constants, sizing helpers and FSM encodings for the AES word bridge.
// The optional key-reuse path is selected by AES_BRIDGE_KEY_REUSE_EN (see the top).
package aes_hpc_word_bridge_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_SHARE = 4;

  function automatic int nwords(input int shares);
    return WORDS_PER_SHARE * shares;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [1:0] in_state_t;
  localparam in_state_t IN_LOAD_KEY = 2'd0;
  localparam in_state_t IN_LOAD_PT  = 2'd1;
  localparam in_state_t IN_ISSUE    = 2'd2;

  typedef logic out_state_t;
  localparam out_state_t OUT_CAPTURE = 1'b0;
  localparam out_state_t OUT_SEND    = 1'b1;

endpackage

// File: rtl/aes_hpc_word_bridge_serializer.sv
// Captures one 128*d-bit sharing on a valid/ready handshake and replays it as
// NW 32-bit words, lowest word first; usable in front of any 128*d-bit source.
module aes_hpc_word_serializer
  import aes_hpc_word_bridge_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [128*d-1:0]    shares_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [WORD_W-1:0]   word,
  output logic                word_last
);

  localparam int NW = nwords(d);
  localparam int CW = cnt_width(NW);
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  out_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q [NW];
  logic              capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      OUT_CAPTURE: begin
        if (in_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = OUT_SEND;
        end
      end
      default: begin
        if (word_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = OUT_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_CAPTURE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buffer is written only in CAPTURE, so it stays frozen for the whole SEND.
  for (genvar gi = 0; gi < NW; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (rst) begin
        buf_q[gi] <= '0;
      end else if (capture) begin
        buf_q[gi] <= shares_in[WORD_W*gi +: WORD_W];
      end
    end
  end

  assign in_ready   = (state_q == OUT_CAPTURE);
  assign word_valid = (state_q == OUT_SEND);
  assign word_last  = word_valid && (cnt_q == LAST_IDX);
  assign word       = buf_q[cnt_q];

endmodule

// File: rtl/aes_hpc_word_bridge.sv
// Word-stream front end for the masked AES core: loads key/plaintext sharings
// from 32-bit words, issues them, and serializes ciphertexts back to words.
// Define AES_BRIDGE_KEY_REUSE_EN to add key_reuse (skip the key load next time).
module aes_hpc_word_bridge
  import aes_hpc_word_bridge_pkg::*;
#(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef AES_BRIDGE_KEY_REUSE_EN
  input  logic               key_reuse,
`endif
  input  logic               in_word_valid,
  output logic               in_word_ready,
  input  logic [31:0]        in_word,
  output logic               aes_in_valid,
  input  logic               aes_in_ready,
  output logic [128*d-1:0]   aes_shares_key,
  output logic [128*d-1:0]   aes_shares_plaintext,
  input  logic [128*d-1:0]   aes_shares_ciphertext,
  input  logic               aes_out_valid,
  output logic               aes_out_ready,
  output logic               out_word_valid,
  input  logic               out_word_ready,
  output logic [31:0]        out_word,
  output logic               out_word_last
);

  localparam int NW = nwords(d);
  localparam int CW = cnt_width(NW);
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  in_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_in_q, cnt_in_d;
  logic [WORD_W-1:0] key_q [NW];
  logic [WORD_W-1:0] pt_q  [NW];
  logic              in_hs;
  logic              key_we;
  logic              pt_we;
  logic              next_is_pt;

`ifdef AES_BRIDGE_KEY_REUSE_EN
  assign next_is_pt = key_reuse;
`else
  assign next_is_pt = 1'b0;
`endif

  // Ready depends only on the registered state, never on in_word_valid.
  assign in_word_ready = (state_q != IN_ISSUE);
  assign aes_in_valid  = (state_q == IN_ISSUE);
  assign in_hs         = in_word_valid && in_word_ready;
  assign key_we        = in_hs && (state_q == IN_LOAD_KEY);
  assign pt_we         = in_hs && (state_q == IN_LOAD_PT);

  always_comb begin
    state_d  = state_q;
    cnt_in_d = cnt_in_q;
    case (state_q)
      IN_LOAD_KEY, IN_LOAD_PT: begin
        if (in_hs) begin
          if (cnt_in_q == LAST_IDX) begin
            cnt_in_d = '0;
            state_d  = (state_q == IN_LOAD_KEY) ? IN_LOAD_PT : IN_ISSUE;
          end else begin
            cnt_in_d = cnt_in_q + 1'b1;
          end
        end
      end
      IN_ISSUE: begin
        if (aes_in_ready) begin
          state_d = next_is_pt ? IN_LOAD_PT : IN_LOAD_KEY;
        end
      end
      default: begin
        state_d  = IN_LOAD_KEY;
        cnt_in_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IN_LOAD_KEY;
      cnt_in_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_in_q <= cnt_in_d;
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_in_buf
    always_ff @(posedge clk) begin
      if (rst) begin
        key_q[gi] <= '0;
        pt_q[gi]  <= '0;
      end else begin
        if (key_we && (cnt_in_q == CW'(gi))) begin
          key_q[gi] <= in_word;
        end
        if (pt_we && (cnt_in_q == CW'(gi))) begin
          pt_q[gi] <= in_word;
        end
      end
    end
    assign aes_shares_key[WORD_W*gi +: WORD_W]       = key_q[gi];
    assign aes_shares_plaintext[WORD_W*gi +: WORD_W] = pt_q[gi];
  end

  aes_hpc_word_serializer #(
    .d (d)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .shares_in  (aes_shares_ciphertext),
    .in_valid   (aes_out_valid),
    .in_ready   (aes_out_ready),
    .word_valid (out_word_valid),
    .word_ready (out_word_ready),
    .word       (out_word),
    .word_last  (out_word_last)
  );

endmodule

// File: tb/tb_aes_hpc_word_bridge.sv
// Directed bench for aes_hpc_word_bridge at d=2 (NW=8); key-reuse steps are
// compiled in only when AES_BRIDGE_KEY_REUSE_EN is defined.
module tb_aes_hpc_word_bridge;

  localparam int D  = 2;
  localparam int NW = 8;

  logic           clk = 1'b0;
  logic           rst;
`ifdef AES_BRIDGE_KEY_REUSE_EN
  logic           key_reuse;
`endif
  logic           in_word_valid;
  logic           in_word_ready;
  logic [31:0]    in_word;
  logic           aes_in_valid;
  logic           aes_in_ready;
  logic [255:0]   aes_shares_key;
  logic [255:0]   aes_shares_plaintext;
  logic [255:0]   aes_shares_ciphertext;
  logic           aes_out_valid;
  logic           aes_out_ready;
  logic           out_word_valid;
  logic           out_word_ready;
  logic [31:0]    out_word;
  logic           out_word_last;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aes_hpc_word_bridge #(.d(D)) dut (
    .clk                   (clk),
    .rst                   (rst),
`ifdef AES_BRIDGE_KEY_REUSE_EN
    .key_reuse             (key_reuse),
`endif
    .in_word_valid         (in_word_valid),
    .in_word_ready         (in_word_ready),
    .in_word               (in_word),
    .aes_in_valid          (aes_in_valid),
    .aes_in_ready          (aes_in_ready),
    .aes_shares_key        (aes_shares_key),
    .aes_shares_plaintext  (aes_shares_plaintext),
    .aes_shares_ciphertext (aes_shares_ciphertext),
    .aes_out_valid         (aes_out_valid),
    .aes_out_ready         (aes_out_ready),
    .out_word_valid        (out_word_valid),
    .out_word_ready        (out_word_ready),
    .out_word              (out_word),
    .out_word_last         (out_word_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] seq(input logic [31:0] base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  // Presents one word and holds it until accepted; valid is left high.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_word       = w;
    in_word_valid = 1'b1;
    while (!in_word_ready && n < 40) begin
      step();
      n++;
    end
    chk("in_ready_wait", 256'(n < 40), 256'd1);
    step();
  endtask

  task automatic send_words(input logic [31:0] base, input int count);
    for (int k = 0; k < count; k++) send_word(base + 32'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] key_exp;
    logic [255:0] pt_exp;
    rst = 1'b1;
`ifdef AES_BRIDGE_KEY_REUSE_EN
    key_reuse = 1'b0;
`endif
    in_word_valid = 1'b0;
    in_word = '0;
    aes_in_ready = 1'b0;
    aes_shares_ciphertext = '0;
    aes_out_valid = 1'b0;
    out_word_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", in_word_ready, 1);
    chk("rst_out_ready", aes_out_ready, 1);
    chk("rst_aes_in_valid", aes_in_valid, 0);
    chk("rst_out_valid", out_word_valid, 0);
    chk("rst_out_last", out_word_last, 0);
    chk("rst_key", aes_shares_key, 0);
    chk("rst_pt", aes_shares_plaintext, 0);
    chk("rst_out_word", out_word, 0);

    // First transaction, no host stalls
    send_words(32'h0, NW);
    send_words(32'h10, NW - 1);
    chk("t1_valid_before_last", aes_in_valid, 0);
    chk("t1_ready_before_last", in_word_ready, 1);
    send_word(32'h17);
    in_word_valid = 1'b0;
    key_exp = seq(32'h0);
    pt_exp  = seq(32'h10);
    chk("t1_aes_in_valid", aes_in_valid, 1);
    chk("t1_in_ready_low", in_word_ready, 0);
    chk("t1_key_w0", aes_shares_key[31:0], 32'h0);
    chk("t1_key_w7", aes_shares_key[255:224], 32'h7);
    chk("t1_key", aes_shares_key, key_exp);
    chk("t1_pt", aes_shares_plaintext, pt_exp);

    // Core stalls in ISSUE for 5 cycles while a 17th word is offered
    in_word       = 32'hAA;
    in_word_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("issue_hold_valid", aes_in_valid, 1);
      chk("issue_hold_ready", in_word_ready, 0);
      chk("issue_hold_key", aes_shares_key, key_exp);
      chk("issue_hold_pt", aes_shares_plaintext, pt_exp);
    end

    // Issue handshake and ciphertext capture in the same cycle
    in_word_valid = 1'b0;
    aes_in_ready = 1'b1;
    aes_out_valid = 1'b1;
    aes_shares_ciphertext = seq(32'hC0);
    step();
    aes_in_ready = 1'b0;
    aes_out_valid = 1'b0;
    chk("hs_aes_in_valid_low", aes_in_valid, 0);
    chk("hs_in_ready_back", in_word_ready, 1);
    chk("cap_out_valid", out_word_valid, 1);
    chk("cap_out_ready_low", aes_out_ready, 0);

    // Serialize with out_word_ready toggling 1/0
    for (int k = 0; k < NW; k++) begin
      out_word_ready = 1'b1;
      chk("ser_word", out_word, 32'hC0 + 32'(k));
      chk("ser_last", out_word_last, (k == NW - 1));
      chk("ser_valid", out_word_valid, 1);
      chk("ser_out_ready", aes_out_ready, 0);
      step();
      out_word_ready = 1'b0;
      if (k < NW - 1) begin
        chk("ser_stall_word", out_word, 32'hC0 + 32'(k + 1));
        chk("ser_stall_ready", aes_out_ready, 0);
        step();
      end
    end
    chk("ser_done_valid", out_word_valid, 0);
    chk("ser_done_out_ready", aes_out_ready, 1);

    // Reset after 5 key words discards the partial load
    send_words(32'hDEAD0000, 5);
    in_word_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_word_ready, 1);
    chk("mid_rst_key", aes_shares_key, 0);
    chk("mid_rst_aes_in_valid", aes_in_valid, 0);
    send_words(32'h20, NW);
    send_words(32'h30, NW);
    in_word_valid = 1'b0;
    chk("t2_aes_in_valid", aes_in_valid, 1);
    chk("t2_key", aes_shares_key, seq(32'h20));
    chk("t2_pt", aes_shares_plaintext, seq(32'h30));
    aes_in_ready = 1'b1;
    step();
    aes_in_ready = 1'b0;

    // Overlap: load and issue while SEND is stalled
    aes_out_valid = 1'b1;
    aes_shares_ciphertext = seq(32'hC0);
    step();
    aes_shares_ciphertext = seq(32'hE0);
    out_word_ready = 1'b0;
    send_words(32'h40, NW);
    send_words(32'h50, NW);
    in_word_valid = 1'b0;
    chk("ovl_aes_in_valid", aes_in_valid, 1);
    chk("ovl_key", aes_shares_key, seq(32'h40));
    chk("ovl_pt", aes_shares_plaintext, seq(32'h50));
    chk("ovl_out_word_held", out_word, 32'hC0);
    chk("ovl_out_ready_low", aes_out_ready, 0);
    aes_in_ready = 1'b1;
    step();
    aes_in_ready = 1'b0;
    chk("ovl_issue_done", in_word_ready, 1);
    out_word_ready = 1'b1;
    for (int k = 0; k < NW; k++) begin
      chk("ovl_word_a", out_word, 32'hC0 + 32'(k));
      chk("ovl_last_a", out_word_last, (k == NW - 1));
      step();
    end
    chk("ovl_gap_valid", out_word_valid, 0);
    chk("ovl_gap_out_ready", aes_out_ready, 1);
    step();
    aes_out_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk("ovl_word_b", out_word, 32'hE0 + 32'(k));
      chk("ovl_valid_b", out_word_valid, 1);
      step();
    end
    out_word_ready = 1'b0;
    chk("ovl_drained", out_word_valid, 0);

`ifdef AES_BRIDGE_KEY_REUSE_EN
    // Key reuse: next transaction loads plaintext only
    send_words(32'h60, NW);
    send_words(32'h70, NW);
    in_word_valid = 1'b0;
    key_reuse = 1'b1;
    aes_in_ready = 1'b1;
    step();
    key_reuse = 1'b0;
    aes_in_ready = 1'b0;
    send_words(32'h80, NW - 1);
    chk("reuse_not_yet", aes_in_valid, 0);
    send_word(32'h87);
    in_word_valid = 1'b0;
    chk("reuse_aes_in_valid", aes_in_valid, 1);
    chk("reuse_key_kept", aes_shares_key, seq(32'h60));
    chk("reuse_pt_new", aes_shares_plaintext, seq(32'h80));
    aes_in_ready = 1'b1;
    step();
    aes_in_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_hpc_word_bridge.md
Name: aes_hpc_word_bridge

Overview:
- Host-side initiator for the masked AES core's 128*d-bit valid/ready interfaces.
- Deserializes a 32-bit word stream of key and plaintext shares into full sharings, then issues one core transaction.
- Serializes each returned ciphertext sharing back into 32-bit words.
- Sits between a narrow bus (AXI-stream-like) and the AES top. Input and output sides run independently, so the next load overlaps draining of the previous result.

Parameters:
- d, 2: number of shares (d >= 2). Each sharing is 4*d words; NW = 4*d.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_word_valid  in  1  host word stream valid.
- in_word_ready  out  1  host word stream ready.
- in_word  in  32  host word.
- aes_in_valid  out  1  to core in_valid.
- aes_in_ready  in  1  from core in_ready.
- aes_shares_key  out  128*d  key sharing; share i at bits [128*i +: 128].
- aes_shares_plaintext  out  128*d  plaintext sharing, same layout.
- aes_shares_ciphertext  in  128*d  ciphertext sharing, same layout.
- aes_out_valid  in  1  core ciphertext valid.
- aes_out_ready  out  1  core ciphertext ready.
- out_word_valid  out  1  host output valid.
- out_word_ready  in  1  host output ready.
- out_word  out  32  host output word.
- out_word_last  out  1  marks the final (NW-1) word of a ciphertext.

Behaviour:
- Word order per transaction:
  - NW key words first. Word k fills aes_shares_key[32*k +: 32], so words 0..3 are share 0 with bits 31:0 first.
  - Then NW plaintext words with the same mapping.
- Input FSM states: LOAD_KEY, LOAD_PT, ISSUE.
  - LOAD_KEY: in_word_ready=1. On each handshake, write the word and increment cnt_in. On cnt_in==NW-1, clear cnt_in and go to LOAD_PT.
  - LOAD_PT: identical behaviour; on cnt_in==NW-1, go to ISSUE.
  - ISSUE: in_word_ready=0, aes_in_valid=1. Key and plaintext buffers are held stable. On aes_in_ready, go to LOAD_KEY (or per the optional feature).
  - aes_in_valid is never deasserted before the handshake.
- Output FSM states: CAPTURE, SEND.
  - CAPTURE: aes_out_ready=1. On aes_out_valid, register the full 128*d ciphertext, clear cnt_out and go to SEND.
  - SEND: aes_out_ready=0, out_word_valid=1, out_word = buf[32*cnt_out +: 32], out_word_last = (cnt_out==NW-1). On out_word_ready, increment cnt_out. On the last word, go to CAPTURE.
- Timing:
  - All ready/valid outputs are register-derived. There is no combinational path from any valid input to any ready output.
  - Minimum load latency: 2*NW accepted words, then aes_in_valid rises the cycle after the last word.
  - First out_word_valid comes one cycle after the capture handshake.
  - The output side accepts one ciphertext per NW+1 cycles when the host never stalls.
- Counters are clog2(NW) bits wide, cleared on wrap and never exceed NW-1. Word and last outputs are meaningful only while valid.
- Reset (including mid-transfer):
  - Input FSM goes to LOAD_KEY, output FSM to CAPTURE, counters to 0, all buffers to 0.
  - All outputs after reset: in_word_ready=1, aes_out_ready=1; aes_in_valid, out_word_valid and out_word_last are 0; data outputs are 0.
  - A partially loaded transaction is discarded.
- Simultaneous events: an input ISSUE handshake and an output capture in the same cycle are independent and both take effect.

Optional Feature:
- Macro: AES_BRIDGE_KEY_REUSE_EN.
- Enabled:
  - Adds input port key_reuse (1 bit), sampled only in ISSUE on the aes_in_ready handshake.
  - If key_reuse=1, the next state is LOAD_PT: the key buffer is retained and only NW plaintext words are loaded.
  - If key_reuse=0, the next state is LOAD_KEY.
  - After reset the first transaction always starts in LOAD_KEY.
- Disabled: the key_reuse port is absent and every transaction loads the key.

Decomposition:
- Shared package:
  - WORD_W=32, WORDS_PER_SHARE=4.
  - Function nwords(d)=4*d and a counter-width function.
  - Input and output FSM state encodings.
- One sub-module: aes_hpc_word_serializer, the output FSM plus ciphertext buffer with parameter d. It is reusable for other 128*d sinks.

Test Plan (d=2, NW=8):
- Key words 0x00000000..0x00000007, plaintext words 0x10..0x17, host never stalls:
  - aes_shares_key[31:0]=0, aes_shares_key[255:224]=7.
  - aes_in_valid rises the cycle after word 15.
  - in_word_ready=0 until aes_in_ready.
- Hold aes_in_ready=0 for 5 cycles in ISSUE: aes_in_valid and both share buses stay constant. The 17th word is not accepted until the handshake.
- Core returns ciphertext with bits [32*k +: 32]=0xC0+k, and out_word_ready toggles 1/0:
  - Words 0xC0..0xC7 appear in order.
  - out_word_last is set only with 0xC7.
  - aes_out_ready=0 throughout SEND.
- Assert rst after 5 key words, then load a full fresh transaction: the issued key equals only the post-reset words and all counters restart at 0.
- Overlap: while SEND is stalled by out_word_ready=0, load and issue a second transaction. The input side completes unaffected and the second ciphertext is captured only after 0xC7 is sent.
- With AES_BRIDGE_KEY_REUSE_EN and key_reuse=1 at issue: the next transaction accepts exactly 8 words, the key bus is unchanged, and the plaintext bus is updated.
